// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencing controller: steps the UART datapath through one 8N1 frame,
// checks start/stop bits and hands each byte to the host through a valid/ready register.
module uart_rx_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_bit,
    input  logic       get_value,
    input  logic       data_received,
    input  logic       stop,
    input  logic [7:0] data_out,
    output logic       bit_clr,
    output logic       take_value,
    output logic       incre_counter,
    output logic       get_output,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err,
    output logic       overrun,
    input  logic       clr_status,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StLoad,
        StOut,
        StWaitHigh
    } state_e;

    state_e     state_q, state_d;
    logic       stop_ok_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rx_err_q;
    logic       overrun_q;
    logic       deliver;
    logic       accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_clr       = 1'b0;
        take_value    = 1'b0;
        incre_counter = 1'b0;
        get_output    = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_clr = 1'b1;
                if (start_bit) state_d = StStart;
            end
            StStart: begin
                if (get_value) begin
                    if (start_bit) begin
                        take_value    = 1'b1;
                        incre_counter = 1'b1;
                        state_d       = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StShift: begin
                if (get_value) begin
                    take_value    = 1'b1;
                    incre_counter = 1'b1;
                end
                if (data_received) state_d = StLoad;
            end
            StLoad: begin
                get_output = 1'b1;
                state_d    = StOut;
            end
            StOut: begin
                if (stop) state_d = stop_ok_q ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                // Hold off until the line returns high so a break is not seen as a start
                bit_clr = 1'b1;
                if (!start_bit) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign deliver = (state_q == StOut) && stop;
    assign accept  = !rx_valid_q || rx_ready;

    // The last sample taken in SHIFT is the stop bit, so stop_ok ends up holding it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stop_ok_q <= 1'b0;
        end else if ((state_q == StShift) && get_value) begin
            stop_ok_q <= ~start_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else if (deliver && accept) begin
            rx_data_q  <= data_out;
            rx_err_q   <= ~stop_ok_q;
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    // A dropped frame outranks a simultaneous status clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (deliver && !accept) begin
            overrun_q <= 1'b1;
        end else if (clr_status) begin
            overrun_q <= 1'b0;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a behavioural receive datapath plus a scoreboard of expected
// {err, byte} pairs checked whenever the host accepts a byte.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       line;
    logic       start_bit;
    logic       get_value;
    logic       data_received;
    logic       stop;
    logic [7:0] data_out;
    logic       bit_clr;
    logic       take_value;
    logic       incre_counter;
    logic       get_output;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_err;
    logic       overrun;
    logic       clr_status;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;
    int n_tv = 0;
    int n_go = 0;
    int n_valid = 0;
    int n_rx = 0;

    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    assign start_bit = ~line;

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_bit    (start_bit),
        .get_value    (get_value),
        .data_received(data_received),
        .stop         (stop),
        .data_out     (data_out),
        .bit_clr      (bit_clr),
        .take_value   (take_value),
        .incre_counter(incre_counter),
        .get_output   (get_output),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_err       (rx_err),
        .overrun      (overrun),
        .clr_status   (clr_status),
        .busy         (busy)
    );

    // Datapath model: 10-bit LSB-first shifter, sample counter, output register
    logic [3:0] dp_cnt;
    logic [9:0] dp_sh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_cnt   <= 4'd0;
            dp_sh    <= 10'd0;
            data_out <= 8'h00;
            stop     <= 1'b0;
        end else begin
            stop <= get_output;
            if (get_output) data_out <= dp_sh[8:1];
            if (take_value) dp_sh <= {line, dp_sh[9:1]};
            if (bit_clr) dp_cnt <= 4'd0;
            else if (incre_counter) dp_cnt <= dp_cnt + 4'd1;
        end
    end

    assign data_received = (dp_cnt == 4'd10);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (take_value) n_tv++;
        if (get_output) n_go++;
        if (rx_valid) n_valid++;
        if (reset && rx_valid && rx_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_byte", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [8:0] exp;
                exp = sb_q.pop_front();
                check_eq("rx_data", 32'(rx_data), 32'(exp[7:0]));
                check_eq("rx_err", 32'(rx_err), 32'(exp[8]));
                n_rx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit period of 8 clocks with the mid-bit strobe on the 4th
    task automatic drive_bit(input logic v, input int tail);
        line = v;
        repeat (3) tick();
        get_value = 1'b1;
        tick();
        get_value = 1'b0;
        repeat (tail) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int nbits,
                              input int last_tail);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(bits[i], (i == 9) ? last_tail : 4);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_bit_clr"}, 32'(bit_clr), 32'd1);
        check_eq({tag, "_take_value"}, 32'(take_value), 32'd0);
        check_eq({tag, "_get_output"}, 32'(get_output), 32'd0);
        check_eq({tag, "_rx_data"}, 32'(rx_data), 32'h00);
        check_eq({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check_eq({tag, "_rx_err"}, 32'(rx_err), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int tv0, go0, va0, rx0;
        reset      = 1'b0;
        line       = 1'b1;
        get_value  = 1'b0;
        rx_ready   = 1'b1;
        clr_status = 1'b0;
        #1;
        check_reset_values("rst_held");
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_values("rst_rel");

        // Clean frame 0xA5
        tv0 = n_tv; go0 = n_go; va0 = n_valid; rx0 = n_rx;
        sb_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, 10, 4);
        repeat (4) tick();
        check_eq("a5_take_value_pulses", 32'(n_tv - tv0), 32'd10);
        check_eq("a5_get_output_pulses", 32'(n_go - go0), 32'd1);
        check_eq("a5_valid_cycles", 32'(n_valid - va0), 32'd1);
        check_eq("a5_delivered", 32'(n_rx - rx0), 32'd1);
        check_eq("a5_busy", 32'(busy), 32'd0);

        // Start glitch
        tv0 = n_tv; va0 = n_valid;
        line = 1'b0;
        repeat (2) tick();
        line = 1'b1;
        tick();
        get_value = 1'b1;
        tick();
        get_value = 1'b0;
        tick();
        check_eq("glitch_take_value", 32'(n_tv - tv0), 32'd0);
        check_eq("glitch_busy", 32'(busy), 32'd0);
        check_eq("glitch_valid", 32'(n_valid - va0), 32'd0);

        // Framing error, line held low afterwards
        sb_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, 10, 4);
        repeat (3) tick();
        check_eq("ferr_wait_busy", 32'(busy), 32'd1);
        check_eq("ferr_wait_bit_clr", 32'(bit_clr), 32'd1);
        line = 1'b1;
        tick();
        check_eq("ferr_idle_busy", 32'(busy), 32'd0);
        check_eq("ferr_overrun", 32'(overrun), 32'd0);

        // Overrun: 0x22 dropped while 0x11 is unread
        rx_ready = 1'b0;
        sb_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b1, 10, 4);
        send_frame(8'h22, 1'b1, 10, 4);
        repeat (4) tick();
        check_eq("ovr_valid", 32'(rx_valid), 32'd1);
        check_eq("ovr_data_held", 32'(rx_data), 32'h11);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'd0);
        check_eq("ovr_valid_kept", 32'(rx_valid), 32'd1);
        rx0 = n_rx;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check_eq("ovr_one_transfer", 32'(n_rx - rx0), 32'd1);
        check_eq("ovr_valid_drop", 32'(rx_valid), 32'd0);
        tick();
        rx_ready = 1'b1;

        // Reset mid-frame of 0xFF, then 0x5A
        send_frame(8'hFF, 1'b1, 5, 4);
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        repeat (2) tick();
        line  = 1'b1;
        reset = 1'b1;
        tick();
        sb_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1, 10, 4);
        repeat (4) tick();
        check_eq("post_rst_rx_data", 32'(rx_data), 32'h5A);

        // Back-to-back: second start bit lands in the IDLE cycle right after OUT
        tv0 = n_tv; rx0 = n_rx;
        sb_q.push_back({1'b0, 8'h00});
        sb_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, 10, 3);
        send_frame(8'hFF, 1'b1, 10, 4);
        repeat (4) tick();
        check_eq("b2b_delivered", 32'(n_rx - rx0), 32'd2);
        check_eq("b2b_take_value", 32'(n_tv - tv0), 32'd20);
        check_eq("b2b_overrun", 32'(overrun), 32'd0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receive datapath. It watches the line-low indication and the mid-bit sample strobe, and drives the shift, bit-count, clear and output-load controls needed to capture one 10-bit frame (start bit, 8 data bits LSB first, stop bit). It validates the start and stop bits and presents each received byte to the host through a valid/ready holding register with error and overrun status. It sits between the receive datapath and the host-side consumer.

## Interface
- No parameters. The frame format is fixed at 1 start bit, 8 data bits and 1 stop bit.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start_bit  in  1  datapath: line currently low
- get_value  in  1  datapath: one-cycle mid-bit sample strobe
- data_received  in  1  datapath: 10 samples counted (held until cleared)
- stop  in  1  datapath: data_out updated last cycle (one-cycle pulse)
- data_out  in  8  datapath: assembled byte
- bit_clr  out  1  clear the datapath bit counter
- take_value  out  1  shift the current line sample into the datapath
- incre_counter  out  1  increment the datapath bit counter
- get_output  out  1  load the assembled byte onto data_out
- rx_data  out  8  holding register for the host
- rx_valid  out  1  rx_data holds an unread byte
- rx_ready  in  1  host accepts rx_data
- rx_err  out  1  framing error on the byte in rx_data (qualified by rx_valid)
- overrun  out  1  sticky: a frame was dropped because rx_data was unread
- clr_status  in  1  clears overrun
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, SHIFT, LOAD, OUT, WAIT_HIGH.
- IDLE: bit_clr=1. Go to START when start_bit=1.
- START: on get_value:
  - if start_bit=1, this is a valid start. Assert take_value=1 and incre_counter=1 in the same cycle (combinational on get_value), then go to SHIFT.
  - if start_bit=0, the start was a glitch. Return to IDLE with no shift.
- SHIFT: on each get_value, assert take_value=1 and incre_counter=1 combinationally. Also register stop_ok <= ~start_bit. When data_received=1, go to LOAD. At that point stop_ok holds the stop-bit sample.
- LOAD: get_output=1 for exactly one cycle, then go to OUT.
- OUT: wait for stop=1. On that cycle, deliver the frame:
  - if rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: rx_data <= data_out, rx_err <= ~stop_ok, rx_valid <= 1.
  - otherwise keep the old rx_data and rx_err, and set overrun <= 1. The new frame is dropped.
  - next state: IDLE if stop_ok=1, else WAIT_HIGH.
- WAIT_HIGH: bit_clr=1. Return to IDLE when start_bit=0. This prevents a break or low stop bit from being taken as a new start.
- Host handshake: a transfer happens on a clk edge where rx_valid=1 and rx_ready=1. rx_valid drops on the next cycle unless a new frame loads on that same edge. rx_data is stable while rx_valid=1 and rx_ready=0.
- overrun: set as described in OUT. Cleared by clr_status=1. If set and clear happen on the same edge, set wins.
- Control outputs that are not asserted by the current state are 0.

## Timing
- Reset values: state=IDLE, rx_data=0x00, rx_valid=0, rx_err=0, overrun=0, stop_ok=0, busy=0.
- Because state is IDLE at reset, bit_clr=1 during and immediately after reset. take_value, incre_counter and get_output are 0.
- take_value and incre_counter are Mealy outputs: high only in the cycle where get_value=1, never for more than one cycle per strobe.
- Latency from the data_received rise: LOAD 1 cycle later, datapath stop pulse 1 cycle after LOAD, rx_valid high on the edge after stop. That is 3 clk from data_received to rx_valid.
- If get_value arrives in LOAD or OUT, it is ignored (no shift).
- Reset asserted mid-frame: immediately return to IDLE and restore all reset values. No partial byte is delivered.
- Back-to-back frames: a start_bit seen in IDLE on the cycle after OUT is accepted.

## Test plan
- Frame 0xA5 (line, LSB first: 0,1,0,1,0,0,1,0,1,1), rx_ready=1 -> rx_data=0xA5, rx_valid for 1 cycle, rx_err=0, 10 take_value pulses, 1 get_output pulse.
- Line low for 2 cycles, then high before the first get_value -> return to IDLE, 0 take_value pulses, rx_valid stays 0.
- Frame 0x3C with the stop bit driven 0 -> rx_data=0x3C, rx_err=1, state WAIT_HIGH until the line goes high, then IDLE.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun=1. Pulsing clr_status -> overrun=0. rx_ready=1 -> one transfer of 0x11.
- Reset pulse after the 4th data bit of frame 0xFF -> all outputs at reset values. A following frame 0x5A is received correctly.
- Frames 0x00 and 0xFF back-to-back with rx_ready=1 -> both delivered in order, rx_err=0, overrun=0.
